// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and its environment:
// line config, receiver pulses, read stream and error status.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5,
  parameter int ADDR_WIDTH     = 2
);
  logic                      cfg_wr;
  logic [PRESCALE_WIDTH-1:0] cfg_prescale;
  logic                      cfg_par_en;
  logic                      cfg_par_typ;
  logic                      cfg_pend;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic                      RX_IN;
  logic [DATA_WIDTH-1:0]     rx_p_data;
  logic                      rx_data_valid;
  logic                      rx_par_err;
  logic                      rx_stp_err;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [ADDR_WIDTH:0]       fifo_cnt;
  logic                      frame_busy;
  logic                      ovr_flag;
  logic                      par_flag;
  logic                      stp_flag;
  logic [7:0]                err_cnt;
  logic                      clr_err;

  modport slave (
    input  cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ,
    input  RX_IN, rx_p_data, rx_data_valid, rx_par_err, rx_stp_err,
    input  rd_ready, clr_err,
    output cfg_pend, Prescale, PAR_EN, PAR_TYP,
    output rd_data, rd_valid, fifo_cnt, frame_busy,
    output ovr_flag, par_flag, stp_flag, err_cnt
  );

  modport master (
    output cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ,
    output RX_IN, rx_p_data, rx_data_valid, rx_par_err, rx_stp_err,
    output rd_ready, clr_err,
    input  cfg_pend, Prescale, PAR_EN, PAR_TYP,
    input  rd_data, rd_valid, fifo_cnt, frame_busy,
    input  ovr_flag, par_flag, stp_flag, err_cnt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Control/buffer wrapper for a UART receiver: frame tracking with timeout,
// between-frame config switching, receive FIFO and sticky error status.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 2
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_ctrl_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_WIDTH + 5);
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t                    state, state_next;
  logic                      cfg_apply;
  logic [PRESCALE_WIDTH-1:0] clk_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic                      bit_end, frame_timeout, frame_end;

  logic [PRESCALE_WIDTH-1:0] sh_prescale;
  logic                      sh_par_en, sh_par_typ;

  logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]     wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic                      pop, full, do_push;
  logic [DATA_WIDTH-1:0]     head_next;

  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'b0, inc};
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

  assign bit_end       = (clk_cnt == bus.Prescale - PRESCALE_WIDTH'(1));
  // Last bit index = data + start + stop + optional parity, plus one spare bit.
  assign frame_timeout = bit_end && (bit_cnt == BIT_W'(DATA_WIDTH + 2) + BIT_W'(bus.PAR_EN));
  assign frame_end     = bus.rx_data_valid | bus.rx_par_err | bus.rx_stp_err | frame_timeout;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cfg_apply  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.RX_IN)        state_next = FRAME;
        else if (bus.cfg_pend) cfg_apply  = 1'b1;
      end
      FRAME: if (frame_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (bit_end) begin
      clk_cnt <= '0;
      bit_cnt <= bit_cnt + BIT_W'(1);
    end else begin
      clk_cnt <= clk_cnt + PRESCALE_WIDTH'(1);
    end
  end

  assign bus.frame_busy = (state == FRAME);

  // Shadow always takes a write; the active set only moves from the old shadow.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_prescale  <= PRESCALE_WIDTH'(8);
      sh_par_en    <= 1'b0;
      sh_par_typ   <= 1'b0;
      bus.cfg_pend <= 1'b0;
      bus.Prescale <= PRESCALE_WIDTH'(8);
      bus.PAR_EN   <= 1'b0;
      bus.PAR_TYP  <= 1'b0;
    end else begin
      if (cfg_apply) begin
        bus.Prescale <= sh_prescale;
        bus.PAR_EN   <= sh_par_en;
        bus.PAR_TYP  <= sh_par_typ;
      end
      if (bus.cfg_wr) begin
        sh_prescale  <= bus.cfg_prescale;
        sh_par_en    <= bus.cfg_par_en;
        sh_par_typ   <= bus.cfg_par_typ;
        bus.cfg_pend <= 1'b1;
      end else if (cfg_apply) begin
        bus.cfg_pend <= 1'b0;
      end
    end
  end

  assign bus.rd_valid = (cnt != '0);
  assign bus.fifo_cnt = cnt;
  assign pop          = bus.rd_valid & bus.rd_ready;
  assign full         = (cnt == CNT_W'(FIFO_DEPTH));
  assign do_push      = bus.rx_data_valid & (~full | pop);
  assign rd_ptr_next  = rd_ptr + ADDR_WIDTH'(pop);
  assign cnt_next     = cnt + CNT_W'(do_push) - CNT_W'(pop);

  // The registered head must bypass the incoming byte when it lands in an empty slot.
  always_comb begin
    head_next = mem[rd_ptr_next];
    if ((cnt - CNT_W'(pop)) == '0) head_next = bus.rx_p_data;
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= bus.rx_p_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      bus.rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      rd_ptr <= rd_ptr_next;
      cnt    <= cnt_next;
      if (cnt_next != '0) bus.rd_data <= head_next;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.ovr_flag <= 1'b0;
      bus.par_flag <= 1'b0;
      bus.stp_flag <= 1'b0;
      bus.err_cnt  <= 8'd0;
    end else begin
      bus.ovr_flag <= (bus.ovr_flag & ~bus.clr_err) | (bus.rx_data_valid & full & ~pop);
      bus.par_flag <= (bus.par_flag & ~bus.clr_err) | bus.rx_par_err;
      bus.stp_flag <= (bus.stp_flag & ~bus.clr_err) | bus.rx_stp_err;
      bus.err_cnt  <= sat_add(bus.clr_err ? 8'd0 : bus.err_cnt,
                              {1'b0, bus.rx_par_err} + {1'b0, bus.rx_stp_err});
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 5;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  uart_rx_ctrl #(
    .DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int m_ps, m_pe, m_pt, s_ps, s_pe, s_pt;
  bit m_pend, m_busy, m_ovr, m_par, m_stp;
  int m_age, m_rd, m_err;
  byte unsigned m_q[$];
  byte unsigned t3[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  byte unsigned t4[4] = '{8'h22, 8'h33, 8'h44, 8'h66};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ps = 8; m_pe = 0; m_pt = 0;
    s_ps = 8; s_pe = 0; s_pt = 0;
    m_pend = 0; m_busy = 0; m_age = 0;
    m_q.delete();
    m_rd = 0; m_ovr = 0; m_par = 0; m_stp = 0; m_err = 0;
  endtask

  // One clock of behaviour, from the inputs present at the edge.
  task automatic model_step();
    bit apply;
    int lim;
    apply = !m_busy && bus.RX_IN && m_pend;
    if (!m_busy) begin
      if (!bus.RX_IN) begin
        m_busy = 1;
        m_age = 0;
      end
    end else begin
      lim = (DW + 3 + m_pe) * m_ps;
      m_age++;
      if (bus.rx_data_valid || bus.rx_par_err || bus.rx_stp_err || m_age == lim) m_busy = 0;
    end
    if (apply) begin
      m_ps = s_ps; m_pe = s_pe; m_pt = s_pt;
    end
    if (bus.cfg_wr) begin
      s_ps = bus.cfg_prescale; s_pe = bus.cfg_par_en; s_pt = bus.cfg_par_typ;
      m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    if (bus.clr_err) begin
      m_ovr = 0; m_par = 0; m_stp = 0; m_err = 0;
    end
    if (m_q.size() > 0 && bus.rd_ready) void'(m_q.pop_front());
    if (bus.rx_data_valid) begin
      if (m_q.size() < DEPTH) m_q.push_back(bus.rx_p_data);
      else m_ovr = 1;
    end
    if (bus.rx_par_err) begin m_par = 1; m_err++; end
    if (bus.rx_stp_err) begin m_stp = 1; m_err++; end
    if (m_err > 255) m_err = 255;
    if (m_q.size() > 0) m_rd = m_q[0];
  endtask

  task automatic check_all();
    chk("cfg_pend", bus.cfg_pend, m_pend);
    chk("Prescale", bus.Prescale, m_ps);
    chk("PAR_EN", bus.PAR_EN, m_pe);
    chk("PAR_TYP", bus.PAR_TYP, m_pt);
    chk("frame_busy", bus.frame_busy, m_busy);
    chk("fifo_cnt", bus.fifo_cnt, m_q.size());
    chk("rd_valid", bus.rd_valid, (m_q.size() != 0));
    chk("rd_data", bus.rd_data, m_rd);
    chk("ovr_flag", bus.ovr_flag, m_ovr);
    chk("par_flag", bus.par_flag, m_par);
    chk("stp_flag", bus.stp_flag, m_stp);
    chk("err_cnt", bus.err_cnt, m_err);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.cfg_wr = 0; bus.cfg_prescale = 5'd8; bus.cfg_par_en = 0; bus.cfg_par_typ = 0;
    bus.RX_IN = 1; bus.rx_p_data = '0; bus.rx_data_valid = 0;
    bus.rx_par_err = 0; bus.rx_stp_err = 0; bus.rd_ready = 0; bus.clr_err = 0;
  endtask

  task automatic push(input byte unsigned b);
    bus.rx_data_valid = 1;
    bus.rx_p_data = b;
    tick();
    bus.rx_data_valid = 0;
  endtask

  task automatic write_cfg(input int ps, input bit pe, input bit pt);
    bus.cfg_wr = 1; bus.cfg_prescale = PW'(ps); bus.cfg_par_en = pe; bus.cfg_par_typ = pt;
    tick();
    bus.cfg_wr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    byte unsigned last;
    RST = 0;
    idle_inputs();
    model_reset();
    #12;
    RST = 1;
    tick();

    // Reset mid-frame with two bytes queued
    push(8'h5A);
    push(8'hC3);
    bus.RX_IN = 0; tick();
    bus.RX_IN = 1; tick(); tick();
    chk("t1_pre_cnt", bus.fifo_cnt, 2);
    chk("t1_pre_busy", bus.frame_busy, 1);
    #3;
    RST = 0;
    model_reset();
    #1;
    check_all();
    chk("t1_ps", bus.Prescale, 8);
    chk("t1_cnt", bus.fifo_cnt, 0);
    tick();
    RST = 1;
    tick();

    // Config written during a frame only applies after it ends
    bus.RX_IN = 0; tick();
    bus.RX_IN = 1; tick();
    write_cfg(16, 1, 1);
    tick();
    chk("t2_pend", bus.cfg_pend, 1);
    chk("t2_ps_hold", bus.Prescale, 8);
    bus.rx_data_valid = 1; bus.rx_p_data = 8'hA5;
    tick();
    bus.rx_data_valid = 0;
    tick();
    chk("t2_ps", bus.Prescale, 16);
    chk("t2_pe", bus.PAR_EN, 1);
    chk("t2_pend_clr", bus.cfg_pend, 0);
    bus.rd_ready = 1; tick(); bus.rd_ready = 0;

    // Overflow and drain order
    foreach (t3[i]) push(t3[i]);
    chk("t3_cnt", bus.fifo_cnt, 4);
    chk("t3_ovr", bus.ovr_flag, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", bus.rd_data, t3[i]);
      bus.rd_ready = 1;
      tick();
    end
    bus.rd_ready = 0;
    chk("t3_empty", bus.rd_valid, 0);
    bus.clr_err = 1; tick(); bus.clr_err = 0;

    // Push and pop together while full
    for (int i = 0; i < 4; i++) push(t3[i]);
    bus.rx_data_valid = 1; bus.rx_p_data = 8'h66; bus.rd_ready = 1;
    tick();
    bus.rx_data_valid = 0;
    chk("t4_ovr", bus.ovr_flag, 0);
    chk("t4_cnt", bus.fifo_cnt, 4);
    last = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", bus.rd_data, t4[i]);
      last = bus.rd_data;
      tick();
    end
    bus.rd_ready = 0;
    chk("t4_last", last, 8'h66);

    // Glitch-aborted frame times out
    write_cfg(8, 0, 0);
    tick(); tick();
    chk("t5_ps", bus.Prescale, 8);
    chk("t5_pe", bus.PAR_EN, 0);
    n = 0;
    bus.RX_IN = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.frame_busy) n++;
    end
    bus.RX_IN = 1;
    for (int i = 0; i < 200 && bus.frame_busy; i++) begin
      tick();
      if (bus.frame_busy) n++;
    end
    chk("t5_busy_clks", n, 88);
    chk("t5_idle", bus.frame_busy, 0);

    // Error counter saturation and clear-then-count
    bus.rx_stp_err = 1;
    repeat (256) tick();
    bus.rx_stp_err = 0;
    chk("t6_sat", bus.err_cnt, 255);
    chk("t6_stp", bus.stp_flag, 1);
    bus.clr_err = 1; bus.rx_par_err = 1;
    tick();
    bus.clr_err = 0; bus.rx_par_err = 0;
    chk("t6_cnt", bus.err_cnt, 1);
    chk("t6_par", bus.par_flag, 1);
    chk("t6_stp_clr", bus.stp_flag, 0);

    // Random traffic
    repeat (3000) begin
      bus.RX_IN = ($urandom_range(0, 9) != 0);
      bus.rx_data_valid = ($urandom_range(0, 19) == 0);
      bus.rx_p_data = DW'($urandom);
      bus.rx_par_err = ($urandom_range(0, 39) == 0);
      bus.rx_stp_err = ($urandom_range(0, 39) == 0);
      bus.cfg_wr = ($urandom_range(0, 29) == 0);
      bus.cfg_prescale = ($urandom_range(0, 1) != 0) ? PW'(16) : PW'(8);
      bus.cfg_par_en = 1'($urandom);
      bus.cfg_par_typ = 1'($urandom);
      bus.rd_ready = 1'($urandom);
      bus.clr_err = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
